csr_tohost_queue: RTL and testbench

Downstream consumer of the pipeline's CSR write path: captures every committed write to CSR `tohost` (0x51E) and buffers it in a small FIFO. It presents the buffered words to the host/testbench over a valid/ready handshake. It raises a stall request when the buffer is full, and flags end-of-test when a value with bit 0 set is written.

---
 rtl/csr_tohost_queue.sv | 92 +++++++++
 tb/tb_csr_tohost_queue.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/csr_tohost_queue.sv
// Captures committed writes to CSR tohost (0x51E) into a small FIFO drained over valid/ready.
// Define TOHOST_DONE_DETECT_EN to compile in the end-of-test (test_done/test_pass) flags.
module csr_tohost_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic [11:0]              csr_i,
  input  logic                     csr_we,
  input  logic [WIDTH-1:0]         wb_data,
  output logic                     full_stall,
  output logic                     host_valid,
  output logic [WIDTH-1:0]         host_data,
  input  logic                     host_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     test_done,
  output logic                     test_pass
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [11:0] TOHOST_CSR = 12'h51E;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic wr_c;
  logic full_c;
  logic enq_c;
  logic deq_c;

  // Handshake and status are decodes of registered occupancy only.
  assign wr_c       = !stall && csr_we && (csr_i == TOHOST_CSR);
  assign full_c     = (count == FULL_CNT);
  assign enq_c      = wr_c && !full_c;
  assign deq_c      = host_valid && host_ready;
  assign full_stall = full_c;
  assign host_valid = (count != '0);
  assign host_data  = mem[rd_ptr];

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (enq_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq_c) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq_c, deq_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (wr_c && full_c) overflow <= 1'b1;
    end
  end

  // Storage is intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (enq_c) mem[wr_ptr] <= wb_data;
  end

`ifdef TOHOST_DONE_DETECT_EN
  logic done_q;
  logic pass_q;

  // Latch the first accepted odd value; later writes leave the verdict alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else if (enq_c && wb_data[0] && !done_q) begin
      done_q <= 1'b1;
      pass_q <= (wb_data == WIDTH'(1));
    end
  end

  assign test_done = done_q;
  assign test_pass = pass_q;
`else
  assign test_done = 1'b0;
  assign test_pass = 1'b0;
`endif

endmodule

// File: tb/tb_csr_tohost_queue.sv
// Directed plus randomized bench for csr_tohost_queue against a queue-based reference model.
module tb_csr_tohost_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              stall = 1'b0;
  logic [11:0]       csr_i = '0;
  logic              csr_we = 1'b0;
  logic [WIDTH-1:0]  wb_data = '0;
  logic              host_ready = 1'b0;
  logic              full_stall;
  logic              host_valid;
  logic [WIDTH-1:0]  host_data;
  logic [2:0]        count;
  logic              overflow;
  logic              test_done;
  logic              test_pass;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  bit m_ovf  = 0;
  bit m_done = 0;
  bit m_pass = 0;

  csr_tohost_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .csr_i      (csr_i),
    .csr_we     (csr_we),
    .wb_data    (wb_data),
    .full_stall (full_stall),
    .host_valid (host_valid),
    .host_data  (host_data),
    .host_ready (host_ready),
    .count      (count),
    .overflow   (overflow),
    .test_done  (test_done),
    .test_pass  (test_pass)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference behaviour for one clock edge, using the inputs currently applied.
  task automatic model_edge();
    bit wr;
    bit full;
    if (reset) begin
      q.delete();
      m_ovf = 0; m_done = 0; m_pass = 0;
      return;
    end
    wr   = !stall && csr_we && (csr_i == 12'h51E);
    full = (q.size() == DEPTH);
    if (q.size() != 0 && host_ready) void'(q.pop_front());
    if (wr) begin
      if (full) m_ovf = 1;
      else begin
        q.push_back(wb_data);
`ifdef TOHOST_DONE_DETECT_EN
        if (!m_done && wb_data[0]) begin
          m_done = 1;
          m_pass = (wb_data == 32'd1);
        end
`endif
      end
    end
  endtask

  task automatic check_all();
    check("count", 32'(count), 32'(q.size()));
    check("host_valid", 32'(host_valid), 32'(q.size() != 0));
    if (q.size() != 0) check("host_data", host_data, q[0]);
    check("full_stall", 32'(full_stall), 32'(q.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("test_done", 32'(test_done), 32'(m_done));
    check("test_pass", 32'(test_pass), 32'(m_pass));
  endtask

  // Apply inputs at the falling edge, advance one clock, check at the next falling edge.
  task automatic cycle(input bit rst, input bit st, input bit we, input logic [11:0] ci,
                       input logic [31:0] d, input bit rdy);
    reset = rst; stall = st; csr_we = we; csr_i = ci; wb_data = d; host_ready = rdy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic wr(input logic [31:0] d, input bit rdy);
    cycle(0, 0, 1, 12'h51E, d, rdy);
  endtask

  task automatic idle(input bit rdy);
    cycle(0, 0, 0, 12'h000, 32'h0, rdy);
  endtask

  initial begin
    @(negedge clk);
    cycle(1, 0, 0, 12'h000, 32'h0, 0);
    cycle(1, 0, 1, 12'h51E, 32'h5, 0);
    idle(0);
    check("reset_count", 32'(count), 32'd0);

    // Single write then one-cycle accept
    wr(32'hDEAD0000, 0);
    check("single_data", host_data, 32'hDEAD0000);
    idle(1);
    check("single_popped", 32'(count), 32'd0);

    // Filtering
    cycle(0, 0, 1, 12'h300, 32'h11, 0);
    cycle(0, 1, 1, 12'h51E, 32'h12, 0);
    cycle(0, 0, 0, 12'h51E, 32'h13, 0);
    check("filter_count", 32'(count), 32'd0);

    // Fill, overflow, ordered drain
    for (int i = 1; i <= 4; i++) wr(32'(i * 16), 0);
    check("fill_full_stall", 32'(full_stall), 32'd1);
    wr(32'h50, 0);
    check("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check("drain_word", host_data, 32'(i * 16));
      idle(1);
    end

    // Wrap with concurrent push/pop at count 2, then write+pop while full
    cycle(1, 0, 0, 12'h000, 32'h0, 0);
    wr(32'h100, 0);
    wr(32'h101, 0);
    for (int i = 2; i < 12; i++) begin
      wr(32'h100 + 32'(i), 1);
      check("wrap_count", 32'(count), 32'd2);
    end
    wr(32'h200, 0);
    wr(32'h201, 0);
    wr(32'h202, 1);
    check("full_pop_count", 32'(count), 32'd3);
    check("full_pop_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) idle(1);

    // End-of-test sequence
    cycle(1, 0, 0, 12'h000, 32'h0, 0);
    wr(32'h2, 1);
    wr(32'h7, 1);
    wr(32'h1, 1);
    idle(1);
    cycle(1, 0, 0, 12'h000, 32'h0, 0);
    wr(32'h1, 1);
    idle(1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit rst, st, we, rdy;
      logic [11:0] ci;
      logic [31:0] d;
      int sel;
      rst = ($urandom_range(0, 199) == 0);
      st  = ($urandom_range(0, 7) == 0);
      we  = ($urandom_range(0, 3) != 0);
      ci  = ($urandom_range(0, 3) != 0) ? 12'h51E : 12'($urandom);
      rdy = ($urandom_range(0, 99) < ((n / 500) % 2 == 0 ? 30 : 70));
      sel = $urandom_range(0, 49);
      d   = (sel == 0) ? 32'h1 : (sel == 1) ? ($urandom | 32'h1) : ($urandom & 32'hFFFF_FFFE);
      cycle(rst, st, we, ci, d, rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
